uart_cmd_parser: RTL and testbench

Frame parser directly downstream of the UART receiver in the top-level UART block. It consumes the receiver's byte stream (`rx_data`/`rx_data_valid`) and extracts 4-byte command frames: sync, command, argument, checksum. Each validated frame is presented as a one-cycle strobe with held command/argument registers for the tone and LED logic. Malformed or stalled frames are dropped and counted.

---
 rtl/uart_cmd_parser_pkg.sv | 25 ++
 rtl/uart_cmd_parser_if.sv | 22 ++
 rtl/uart_cmd_parser_gap_timer.sv | 35 +++
 rtl/uart_cmd_parser.sv | 121 ++++++++++++
 tb/tb_uart_cmd_parser.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART command frame parser: state encoding, frame
// constants and command codes consumed by the tone/LED logic.
package uart_cmd_parser_pkg;

  typedef enum logic [1:0] {
    StHunt,
    StGetCmd,
    StGetArg,
    StGetSum
  } state_e;

  localparam logic [7:0] SyncDefault = 8'hA5;
  localparam logic [7:0] SumKey      = 8'h5A;

  // Command codes understood by the downstream tone and LED blocks.
  localparam logic [7:0] CmdToneOn   = 8'h10;
  localparam logic [7:0] CmdToneOff  = 8'h11;
  localparam logic [7:0] CmdLedSet   = 8'h20;
  localparam logic [7:0] CmdLedClear = 8'h21;

  function automatic logic [7:0] frame_sum(logic [7:0] cmd, logic [7:0] arg);
    return cmd ^ arg ^ SumKey;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte stream in, decoded command strobe and status out, between the UART
// receiver and the command consumers.
interface uart_cmd_parser_if;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       cmd_valid;
  logic [7:0] cmd;
  logic [7:0] arg;
  logic       frame_err;
  logic [7:0] err_cnt;
  logic       busy;

  modport master (
    output rx_data, rx_data_valid,
    input  cmd_valid, cmd, arg, frame_err, err_cnt, busy
  );

  modport slave (
    input  rx_data, rx_data_valid,
    output cmd_valid, cmd, arg, frame_err, err_cnt, busy
  );
endinterface

// File: rtl/uart_cmd_parser_gap_timer.sv
// Terminal-count timer: counts enabled cycles, strobes expired_o combinationally
// when the count sits at Terminal, then wraps to zero.
module gap_timer #(
  parameter int unsigned Terminal = 199999
) (
  input  logic clk_i,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  logic [31:0] count_q, count_d;

  // A clear in the same cycle suppresses expiry so a fresh event always wins.
  assign expired_o = en_i && !clear_i && (count_q == 32'(Terminal));

  always_comb begin
    count_d = count_q;
    if (clear_i || expired_o) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Extracts SYNC/CMD/ARG/SUM frames from the UART byte stream, strobes accepted
// commands and counts checksum or inter-byte timeout errors.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int unsigned clk_fre    = 100,
  parameter int unsigned timeout_us = 2000,
  parameter logic [7:0]  SYNC       = SyncDefault
) (
  input  logic            sys_clk,
  input  logic            rst,
  uart_cmd_parser_if.slave bus
);

  localparam int unsigned TimeoutCycles = clk_fre * timeout_us;

  state_e     state_q, state_d;
  logic [7:0] cmd_sh_q, cmd_sh_d;
  logic [7:0] arg_sh_q, arg_sh_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] arg_q, arg_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic       frame_err_q, frame_err_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       timed_out;
  logic       byte_v;

  assign byte_v = bus.rx_data_valid;

  gap_timer #(
    .Terminal (TimeoutCycles - 1)
  ) u_gap_timer (
    .clk_i     (sys_clk),
    .rst       (rst),
    .clear_i   (byte_v || (state_q == StHunt)),
    .en_i      (state_q != StHunt),
    .expired_o (timed_out)
  );

  always_comb begin
    state_d     = state_q;
    cmd_sh_d    = cmd_sh_q;
    arg_sh_d    = arg_sh_q;
    cmd_d       = cmd_q;
    arg_d       = arg_q;
    cmd_valid_d = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      StHunt: begin
        if (byte_v && bus.rx_data == SYNC) state_d = StGetCmd;
      end
      StGetCmd: begin
        if (byte_v) begin
          cmd_sh_d = bus.rx_data;
          state_d  = StGetArg;
        end
      end
      StGetArg: begin
        if (byte_v) begin
          arg_sh_d = bus.rx_data;
          state_d  = StGetSum;
        end
      end
      StGetSum: begin
        if (byte_v) begin
          if (bus.rx_data == frame_sum(cmd_sh_q, arg_sh_q)) begin
            cmd_d       = cmd_sh_q;
            arg_d       = arg_sh_q;
            cmd_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = StHunt;
        end
      end
      default: state_d = StHunt;
    endcase

    // The timer never expires on a byte cycle, so this cannot clash with the case above.
    if (timed_out) begin
      state_d     = StHunt;
      cmd_sh_d    = '0;
      arg_sh_d    = '0;
      frame_err_d = 1'b1;
    end

    err_cnt_d = err_cnt_q;
    if (frame_err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q     <= StHunt;
      cmd_sh_q    <= '0;
      arg_sh_q    <= '0;
      cmd_q       <= '0;
      arg_q       <= '0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_sh_q    <= cmd_sh_d;
      arg_sh_q    <= arg_sh_d;
      cmd_q       <= cmd_d;
      arg_q       <= arg_d;
      cmd_valid_q <= cmd_valid_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd       = cmd_q;
  assign bus.arg       = arg_q;
  assign bus.frame_err = frame_err_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.busy      = (state_q != StHunt);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Random and directed byte streams against a queue-based frame model; every
// negedge compares all parser outputs with the model's prediction.
module tb_uart_cmd_parser;

  localparam int unsigned ClkFre    = 1;
  localparam int unsigned TimeoutUs = 50;
  localparam int          Gap       = ClkFre * TimeoutUs;
  localparam logic [7:0]  Sync      = 8'hA5;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  logic chk_en  = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  uart_cmd_parser_if bus ();

  uart_cmd_parser #(
    .clk_fre    (ClkFre),
    .timeout_us (TimeoutUs),
    .SYNC       (Sync)
  ) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus.slave)
  );

  always #5 sys_clk = ~sys_clk;

  // Model: bytes of the frame in progress plus idle cycles since the last byte.
  logic [7:0] frm[$];
  int         idle;
  logic       exp_cv, exp_fe, exp_busy, cur_cv, cur_fe, cur_busy;
  logic [7:0] exp_cmd, exp_arg, exp_cnt, cur_cmd, cur_arg, cur_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    frm.delete();
    idle = 0;
    {exp_cv, exp_fe, exp_busy, cur_cv, cur_fe, cur_busy} = '0;
    {exp_cmd, exp_arg, exp_cnt, cur_cmd, cur_arg, cur_cnt} = '0;
  endtask

  task automatic model_error();
    exp_fe = 1'b1;
    if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
  endtask

  // Predicts the outputs that will be visible after the coming clock edge.
  task automatic model_step(input logic v, input logic [7:0] d);
    {cur_cv, cur_fe, cur_busy, cur_cmd, cur_arg, cur_cnt} =
      {exp_cv, exp_fe, exp_busy, exp_cmd, exp_arg, exp_cnt};
    exp_cv = 1'b0;
    exp_fe = 1'b0;
    if (frm.size() == 0) begin
      if (v && d == Sync) frm.push_back(d);
      idle = 0;
    end else if (v) begin
      frm.push_back(d);
      idle = 0;
      if (frm.size() == 4) begin
        if (frm[3] == (frm[1] ^ frm[2] ^ 8'h5A)) begin
          exp_cv  = 1'b1;
          exp_cmd = frm[1];
          exp_arg = frm[2];
        end else begin
          model_error();
        end
        frm.delete();
      end
    end else begin
      idle++;
      if (idle == Gap) begin
        model_error();
        frm.delete();
      end
    end
    exp_busy = (frm.size() != 0);
  endtask

  // Applies one clock of input; returns 1 time unit after the edge.
  task automatic cycle(input logic v, input logic [7:0] d);
    bus.rx_data_valid = v;
    bus.rx_data       = d;
    model_step(v, d);
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap);
    cycle(1'b1, d);
    repeat (gap) cycle(1'b0, 8'h00);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] s,
                            input int gap);
    send_byte(Sync, gap);
    send_byte(c, gap);
    send_byte(a, gap);
    send_byte(s, gap);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " cmd_valid"}, 32'(bus.cmd_valid), 0);
    chk({tag, " cmd"},       32'(bus.cmd),       0);
    chk({tag, " arg"},       32'(bus.arg),       0);
    chk({tag, " frame_err"}, 32'(bus.frame_err), 0);
    chk({tag, " err_cnt"},   32'(bus.err_cnt),   0);
    chk({tag, " busy"},      32'(bus.busy),      0);
  endtask

  always @(negedge sys_clk) begin
    if (chk_en) begin
      chk("cmp cmd_valid", 32'(bus.cmd_valid), 32'(cur_cv));
      chk("cmp frame_err", 32'(bus.frame_err), 32'(cur_fe));
      chk("cmp cmd",       32'(bus.cmd),       32'(cur_cmd));
      chk("cmp arg",       32'(bus.arg),       32'(cur_arg));
      chk("cmp err_cnt",   32'(bus.err_cnt),   32'(cur_cnt));
      chk("cmp busy",      32'(bus.busy),      32'(cur_busy));
    end
  end

  initial begin
    bus.rx_data_valid = 1'b0;
    bus.rx_data       = 8'h00;
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    chk_reset_outputs("reset");
    rst    = 1'b0;
    chk_en = 1'b1;

    // Valid frame, generous gaps below the timeout.
    send_frame(8'h10, 8'h3C, 8'h76, 30);
    chk("t1 cmd", 32'(bus.cmd), 32'h10);
    chk("t1 arg", 32'(bus.arg), 32'h3C);
    chk("t1 err_cnt", 32'(bus.err_cnt), 0);

    // Bad checksum: strobe lands the cycle after the SUM byte.
    send_byte(Sync, 2);
    send_byte(8'h10, 2);
    send_byte(8'h3C, 2);
    cycle(1'b1, 8'h77);
    chk("t2 frame_err", 32'(bus.frame_err), 1);
    chk("t2 cmd_valid", 32'(bus.cmd_valid), 0);
    chk("t2 cmd kept", 32'(bus.cmd), 32'h10);
    chk("t2 err_cnt", 32'(bus.err_cnt), 1);
    cycle(1'b0, 8'h00);

    // Garbage then a valid frame; SYNC inside the frame is plain data.
    send_byte(8'h00, 1);
    send_byte(8'hFF, 0);
    send_byte(8'hA4, 3);
    send_frame(8'hA5, 8'h07, 8'hA5 ^ 8'h07 ^ 8'h5A, 0);
    chk("t3 cmd", 32'(bus.cmd), 32'hA5);
    chk("t3 err_cnt", 32'(bus.err_cnt), 1);

    // Timeout: error strobe after Gap idle cycles following the last byte.
    send_byte(Sync, 0);
    cycle(1'b1, 8'h10);
    repeat (Gap - 1) cycle(1'b0, 8'h00);
    chk("t4 no early err", 32'(bus.frame_err), 0);
    chk("t4 busy before", 32'(bus.busy), 1);
    cycle(1'b0, 8'h00);
    chk("t4 frame_err", 32'(bus.frame_err), 1);
    chk("t4 busy after", 32'(bus.busy), 0);
    chk("t4 err_cnt", 32'(bus.err_cnt), 2);
    send_frame(8'h20, 8'h01, 8'h20 ^ 8'h01 ^ 8'h5A, 1);
    chk("t4 next frame cmd", 32'(bus.cmd), 32'h20);

    // Random streams: good frames, bad sums, garbage, occasional long stalls.
    for (int i = 0; i < 300; i++) begin
      int         kind;
      logic [7:0] c, a, s;
      kind = int'($urandom_range(0, 3));
      c    = 8'($urandom);
      a    = (kind == 3) ? Sync : 8'($urandom);
      s    = c ^ a ^ 8'h5A;
      if (kind == 1) s = s ^ 8'(1 << $urandom_range(0, 7));
      if (kind == 2) begin
        send_byte(8'($urandom), int'($urandom_range(0, 2)));
      end else begin
        for (int b = 0; b < 4; b++) begin
          logic [7:0] byt;
          int         gap;
          byt = (b == 0) ? Sync : (b == 1) ? c : (b == 2) ? a : s;
          gap = ($urandom_range(0, 19) == 0) ? int'($urandom_range(Gap - 3, Gap + 3))
                                             : int'($urandom_range(0, 3));
          send_byte(byt, gap);
        end
      end
    end

    // Saturation: back-to-back bad frames.
    repeat (300) send_frame(8'h10, 8'h3C, 8'h77, 0);
    cycle(1'b0, 8'h00);
    chk("t5 err_cnt sat", 32'(bus.err_cnt), 32'hFF);

    // Reset mid-frame.
    send_frame(8'h11, 8'h22, 8'h11 ^ 8'h22 ^ 8'h5A, 0);
    send_byte(Sync, 0);
    cycle(1'b1, 8'h10);
    chk_en            = 1'b0;
    bus.rx_data_valid = 1'b0;
    rst               = 1'b1;
    #1;
    chk_reset_outputs("t6 reset");
    repeat (2) @(posedge sys_clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk_en = 1'b1;
    send_frame(8'h01, 8'h02, 8'h59, 1);
    chk("t6 cmd", 32'(bus.cmd), 32'h01);
    chk("t6 arg", 32'(bus.arg), 32'h02);
    chk("t6 err_cnt", 32'(bus.err_cnt), 0);

    repeat (4) cycle(1'b0, 8'h00);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
